// File: rtl/seq_fetch.sv
// Program sequencer front end: fetches words from a synchronous-read program
// memory, presents them to the decoder/executor and resolves jumps on transfer.

package seq_fetch_pkg;
   function automatic int get_word_width();
      return 16;
   endfunction

   function automatic int get_jmp_width();
      return 8;
   endfunction
endpackage

module seq_fetch
   import seq_fetch_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int WORD_W = get_word_width(),
   parameter int JMP_W  = get_jmp_width()
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              start_i,
   input  logic              stop_i,
   output logic              mem_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [WORD_W-1:0] mem_data_i,
   output logic [WORD_W-1:0] word_o,
   output logic              word_valid_o,
   input  logic              word_ready_i,
   input  logic              jmp_en_i,
   input  logic              jmp_back_i,
   input  logic [JMP_W-1:0]  jmp_value_i,
   input  logic              jmp_cond_i,
   input  logic              cond_met_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   // One spare bit above the wider operand: a borrow or carry lands there.
   localparam int EXT_W = ((JMP_W > ADDR_W) ? JMP_W : ADDR_W) + 1;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT, S_ERR} state_t;

   state_t              r_state, w_state_nxt;
   logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
   logic [WORD_W-1:0]   r_word, w_word;
   logic                r_fresh;
   logic                r_done, w_done_nxt;
   logic                r_err, w_err_nxt;
   logic [EXT_W-1:0]    w_pc_ext, w_jmp_ext, w_target;
   logic                w_out_of_range, w_taken, w_xfer, w_last;

   assign w_pc_ext       = EXT_W'(r_pc);
   assign w_jmp_ext      = EXT_W'(jmp_value_i);
   assign w_target       = jmp_back_i ? (w_pc_ext - w_jmp_ext) : (w_pc_ext + w_jmp_ext);
   assign w_out_of_range = |w_target[EXT_W-1:ADDR_W];
   assign w_taken        = jmp_en_i & (~jmp_cond_i | cond_met_i);
   assign w_xfer         = (r_state == S_PRESENT) & word_ready_i;
   assign w_last         = &r_pc;

   // Read data only arrives during the first PRESENT cycle, so it is passed
   // straight through then and held from the register afterwards.
   assign w_word = ((r_state == S_PRESENT) && r_fresh) ? mem_data_i : r_word;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_done_nxt  = 1'b0;
      w_err_nxt   = r_err;
      unique case (r_state)
         S_IDLE, S_ERR: begin
            if (start_i) begin
               w_state_nxt = S_FETCH;
               w_pc_nxt    = '0;
               w_err_nxt   = 1'b0;
            end else if (stop_i && (r_state == S_ERR)) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_FETCH: begin
            w_state_nxt = stop_i ? S_IDLE : S_PRESENT;
         end
         S_PRESENT: begin
            if (stop_i) begin
               w_state_nxt = S_IDLE;
            end else if (w_xfer) begin
               if (w_taken && w_out_of_range) begin
                  w_state_nxt = S_ERR;
                  w_err_nxt   = 1'b1;
               end else if (w_taken) begin
                  w_state_nxt = S_FETCH;
                  w_pc_nxt    = w_target[ADDR_W-1:0];
               end else if (w_last) begin
                  w_state_nxt = S_IDLE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = S_FETCH;
                  w_pc_nxt    = r_pc + 1'b1;
               end
            end
         end
      endcase
   end

   always_comb begin
      mem_en_o     = 1'b0;
      mem_addr_o   = '0;
      word_valid_o = 1'b0;
      busy_o       = 1'b0;
      if (r_state == S_FETCH) begin
         mem_en_o   = 1'b1;
         mem_addr_o = r_pc;
         busy_o     = 1'b1;
      end
      if (r_state == S_PRESENT) begin
         word_valid_o = 1'b1;
         busy_o       = 1'b1;
      end
      word_o = w_word;
      done_o = r_done;
      err_o  = r_err;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state <= S_IDLE;
         r_pc    <= '0;
         r_word  <= '0;
         r_fresh <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_word  <= w_word;
         r_fresh <= (r_state == S_FETCH) && (w_state_nxt == S_PRESENT);
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
      end
   end

endmodule

// File: tb/tb_seq_fetch.sv
// Bench for seq_fetch: directed scenarios plus a randomized run, checked by a
// program-level reference model and an expected-fetch scoreboard.

module tb_seq_fetch;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start, stop, ready, cond_met;
   logic        mem_en, valid, busy, done, err;
   logic [7:0]  mem_addr;
   logic [15:0] mem_data, word;
   logic        jmp_en, jmp_back, jmp_cond;
   logic [7:0]  jmp_value;

   logic        s_start, s_mem_en, s_valid, s_busy, s_done, s_err;
   logic [1:0]  s_mem_addr;
   logic [15:0] s_mem_data, s_word;

   logic [15:0] prog [256];
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   // Decoder stand-in: bit15 jump, bit14 back, bit13 compare-jump, [7:0] offset.
   assign jmp_en    = word[15];
   assign jmp_back  = word[14];
   assign jmp_cond  = word[13];
   assign jmp_value = word[7:0];

   seq_fetch u_dut (
      .clk_i(clk), .rstn_i(rstn), .start_i(start), .stop_i(stop),
      .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_data_i(mem_data),
      .word_o(word), .word_valid_o(valid), .word_ready_i(ready),
      .jmp_en_i(jmp_en), .jmp_back_i(jmp_back), .jmp_value_i(jmp_value),
      .jmp_cond_i(jmp_cond), .cond_met_i(cond_met),
      .busy_o(busy), .done_o(done), .err_o(err)
   );

   seq_fetch #(.ADDR_W(2), .WORD_W(16), .JMP_W(2)) u_small (
      .clk_i(clk), .rstn_i(rstn), .start_i(s_start), .stop_i(1'b0),
      .mem_en_o(s_mem_en), .mem_addr_o(s_mem_addr), .mem_data_i(s_mem_data),
      .word_o(s_word), .word_valid_o(s_valid), .word_ready_i(1'b1),
      .jmp_en_i(1'b0), .jmp_back_i(1'b0), .jmp_value_i(2'b00),
      .jmp_cond_i(1'b0), .cond_met_i(1'b0),
      .busy_o(s_busy), .done_o(s_done), .err_o(s_err)
   );

   always @(posedge clk) if (mem_en) mem_data <= prog[mem_addr];
   always @(posedge clk) if (s_mem_en) s_mem_data <= 16'h0100 + 16'(s_mem_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   int          exp_q[$];
   int          m_pc, tgt;
   bit          m_active, m_err, m_done, taken;
   logic [15:0] m_w;

   always @(negedge clk) begin
      if (!rstn) begin
         exp_q.delete();
         m_active = 0; m_err = 0; m_done = 0; m_pc = 0;
      end else begin
         check("busy", 32'(busy), 32'(m_active));
         check("err", 32'(err), 32'(m_err));
         check("done", 32'(done), 32'(m_done));
         if (!m_active) check("valid_idle", 32'(valid), 0);
         m_done = 0;
         if (mem_en) begin
            check("fetch_q", 32'(exp_q.size()), 1);
            if (exp_q.size() > 0) check("sb_addr", 32'(mem_addr), 32'(exp_q.pop_front()));
         end
         if (m_active && stop) begin
            m_active = 0;
            exp_q.delete();
         end else if (m_active && valid && ready) begin
            m_w = prog[m_pc];
            check("sb_word", 32'(word), 32'(m_w));
            taken = m_w[15] && (!m_w[13] || cond_met);
            if (!taken)      tgt = m_pc + 1;
            else if (m_w[14]) tgt = m_pc - int'(m_w[7:0]);
            else             tgt = m_pc + int'(m_w[7:0]);
            if (taken && (tgt < 0 || tgt > 255)) begin
               m_active = 0; m_err = 1;
            end else if (!taken && m_pc == 255) begin
               m_active = 0; m_done = 1;
            end else begin
               m_pc = tgt;
               exp_q.push_back(tgt);
            end
         end else if (!m_active && start) begin
            m_active = 1; m_err = 0; m_pc = 0;
            exp_q.push_back(0);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic start_pulse();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic stop_pulse();
      @(posedge clk); #1 stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
   endtask

   task automatic expect_fetch(input int addr);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_en && n < 30);
      check("fetch_seen", 32'(mem_en), 1);
      check("fetch_addr", 32'(mem_addr), 32'(addr));
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
   endtask

   initial begin
      logic [15:0] held;
      rstn = 1'b0; start = 0; stop = 0; ready = 1; cond_met = 0; s_start = 0;
      clear_prog();
      #3;
      check("rst_mem_en", 32'(mem_en), 0);
      check("rst_addr", 32'(mem_addr), 0);
      check("rst_word", 32'(word), 0);
      check("rst_valid", 32'(valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done_err", 32'({done, err}), 0);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;

      // Linear run on a 4-word program: fetch every 2 cycles, done after word 3.
      @(posedge clk); #1 s_start = 1'b1;
      @(posedge clk); #1 s_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("lin_en", 32'(s_mem_en), 1);
         check("lin_addr", 32'(s_mem_addr), 32'(k));
         @(negedge clk);
         check("lin_valid", 32'({s_valid, s_mem_en}), 32'b10);
         check("lin_word", 32'(s_word), 32'(16'h0100 + k));
         check("lin_done_early", 32'(s_done), 0);
      end
      @(negedge clk);
      check("lin_done", 32'({s_done, s_busy}), 32'b10);
      @(negedge clk);
      check("lin_done_pulse", 32'({s_done, s_busy, s_err}), 0);

      // Backward jump at pc=5, unconditional then compare-jump not met.
      prog[0] = 16'h8005;
      prog[5] = 16'hC003;
      start_pulse();
      expect_fetch(0); expect_fetch(5); expect_fetch(2);
      stop_pulse();
      prog[5] = 16'hE003;
      start_pulse();
      expect_fetch(0); expect_fetch(5); expect_fetch(6);
      stop_pulse();

      // Range error from pc=1 jumping back by 4, then recovery.
      clear_prog();
      prog[0] = 16'h8001;
      prog[1] = 16'hC004;
      start_pulse();
      expect_fetch(0); expect_fetch(1);
      repeat (2) @(negedge clk);
      check("err_set", 32'({err, valid, busy}), 32'b100);
      start_pulse();
      expect_fetch(0);
      check("err_cleared", 32'(err), 0);
      stop_pulse();

      // Stall at pc=3: word held, no fetch, then resume at 4.
      clear_prog();
      prog[3] = 16'h0AB3;
      start_pulse();
      expect_fetch(0); expect_fetch(1); expect_fetch(2); expect_fetch(3);
      @(posedge clk); #1 ready = 1'b0;
      @(negedge clk);
      held = word;
      check("stall_word0", 32'(held), 32'h0AB3);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stall_hold", 32'({valid, mem_en}), 32'b10);
         check("stall_word", 32'(word), 32'(held));
      end
      @(posedge clk); #1 ready = 1'b1;
      expect_fetch(4);
      stop_pulse();

      // Stop together with a transfer of a jump word.
      clear_prog();
      prog[0] = 16'h8007;
      start_pulse();
      expect_fetch(0);
      @(posedge clk); #1 stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("stop_idle", 32'({busy, valid, mem_en, done}), 0);
      end

      // Randomized program and handshake.
      for (int i = 0; i < 256; i++) begin
         int r = int'($urandom_range(0, 9));
         prog[i] = 16'($urandom);
         prog[i][15] = (r < 3);
         prog[i][14] = (r == 1);
         prog[i][13] = 1'($urandom);
         if (r < 3) prog[i][7:0] = 8'($urandom_range(0, 12));
      end
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk); #1;
         ready    = ($urandom_range(0, 3) != 0);
         cond_met = 1'($urandom);
         start    = ($urandom_range(0, 5) == 0);
         stop     = ($urandom_range(0, 79) == 0);
      end
      @(posedge clk); #1 start = 0; stop = 0; ready = 1; cond_met = 0;
      stop_pulse();
      repeat (3) @(negedge clk);

      // Asynchronous reset in the middle of a fetch.
      clear_prog();
      start_pulse();
      expect_fetch(0);
      #2 rstn = 1'b0;
      #1;
      check("arst_mem_en", 32'(mem_en), 0);
      check("arst_outs", 32'({valid, busy, done, err}), 0);
      check("arst_addr_word", 32'({mem_addr, word}), 0);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("post_rst_quiet", 32'({mem_en, valid, busy, done, err}), 0);
         check("post_rst_word", 32'(word), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_fetch.md
SEQ_FETCH -- requirements
Module: seq_fetch

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, program memory address width; WORD_W, default get_word_width(), sequencer word width; JMP_W, default get_jmp_width(), jump offset width.
REQ-002 clk_i  input  1  single clock; all state changes on the rising edge.
REQ-003 rstn_i  input  1  asynchronous, active-low reset.
REQ-004 start_i  input  1  single-cycle pulse; starts program execution from address 0.
REQ-005 stop_i  input  1  single-cycle pulse; aborts execution.
REQ-006 mem_en_o  output  1  program memory read enable.
REQ-007 mem_addr_o  output  ADDR_W  program memory read address.
REQ-008 mem_data_i  input  WORD_W  program memory read data; synchronous read, valid on the cycle after mem_en_o.
REQ-009 word_o  output  WORD_W  fetched word, driven to the decoder.
REQ-010 word_valid_o  output  1  word_o holds a valid word.
REQ-011 word_ready_i  input  1  executor accepts word_o.
REQ-012 jmp_en_i, jmp_back_i  input  1 each  decoder jump flags for word_o (combinational).
REQ-013 jmp_value_i  input  JMP_W  decoder jump offset for word_o.
REQ-014 jmp_cond_i  input  1  the jump is the compare-jump type.
REQ-015 cond_met_i  input  1  compare result from the executor.
REQ-016 busy_o, done_o, err_o  output  1 each  running; end-of-program pulse; sticky jump-range error.

Function
REQ-017 The FSM SHALL have four states: IDLE, FETCH, PRESENT, ERR.
REQ-018 In IDLE, start_i SHALL load pc=0 and move to FETCH; start_i in any other state SHALL be ignored.
REQ-019 In FETCH, mem_en_o=1 and mem_addr_o=pc for exactly one cycle; the next state SHALL be PRESENT.
REQ-020 On entry to PRESENT, word_o SHALL register mem_data_i, and word_valid_o=1.
REQ-021 word_o SHALL hold stable while word_valid_o=1 and word_ready_i=0.
REQ-022 A transfer SHALL occur when word_valid_o and word_ready_i are both 1.
REQ-023 taken = jmp_en_i & (~jmp_cond_i | cond_met_i), sampled at the transfer cycle.
REQ-024 pc_next SHALL be: pc+1 if not taken; pc+jmp_value_i if taken and forward; pc-jmp_value_i if taken and back.
REQ-025 Address arithmetic SHALL use ADDR_W+1 bits with jmp_value_i zero-extended.
REQ-026 A taken jump whose result is below 0 or above 2^ADDR_W-1 SHALL go to ERR, set err_o, and clear word_valid_o.
REQ-027 A not-taken transfer at pc=2^ADDR_W-1 SHALL pulse done_o for one cycle and return to IDLE; there is no wrap.
REQ-028 Any other transfer SHALL load pc=pc_next and go to FETCH on the next cycle.
REQ-029 A taken forward jump with offset 0 SHALL re-fetch the same address; this is legal (self-loop).
REQ-030 Throughput SHALL be one word per 2 cycles with no stall: start at cycle 0, mem_en_o at cycle 1, word_valid_o at cycle 2.
REQ-031 stop_i in any non-IDLE state SHALL go to IDLE next cycle, clear word_valid_o and mem_en_o, and not pulse done_o.
REQ-032 stop_i SHALL win over a simultaneous transfer; that word SHALL be treated as not consumed and pc SHALL not update.
REQ-033 ERR SHALL be left only by start_i, which clears err_o and behaves as in IDLE; stop_i in ERR SHALL go to IDLE and keep err_o.
REQ-034 busy_o SHALL be 1 in FETCH and PRESENT, and 0 otherwise.
REQ-035 mem_en_o SHALL never be 1 outside FETCH.

Reset
REQ-036 rstn_i low SHALL asynchronously force: state=IDLE; pc=0; word_o=0; and mem_en_o, mem_addr_o, word_valid_o, busy_o, done_o, err_o all 0.
REQ-037 Reset asserted mid-operation SHALL discard any in-flight read; after release, no output SHALL change until start_i.

Verification
REQ-038 Linear run, ADDR_W=2, ready always 1, no jumps: start -> addresses 0,1,2,3 fetched every 2 cycles, done_o pulse after word 3, then IDLE.
REQ-039 Backward jump: word at pc=5 with jmp_en=1, back=1, value=3, cond=0 -> next mem_addr_o=2; same with cond=1, cond_met=0 -> next mem_addr_o=6.
REQ-040 Range error: pc=1, back jump value=4 -> err_o=1, word_valid_o=0, busy_o=0; a later start_i clears err_o and fetches address 0.
REQ-041 Stall: word_ready_i low for 5 cycles at pc=3 -> word_o stable, word_valid_o=1, no mem_en_o; ready high -> fetch of address 4.
REQ-042 Stop with simultaneous transfer on a jump word -> IDLE next cycle, pc unchanged, no done_o; mid-FETCH async reset -> all outputs 0 immediately.
